// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet-level AXI-stream arbiter.
package axis_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } arb_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int DEF_NUM_SRC     = 4;
    localparam int DEF_SRC_IDX_LEN = clog2(DEF_NUM_SRC);

endpackage

// File: rtl/axis_pkt_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: first requester strictly after last_grant, wrapping.
module rr_pick
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC     = DEF_NUM_SRC,
    parameter int SRC_IDX_LEN = DEF_SRC_IDX_LEN
) (
    input  logic [NUM_SRC-1:0]     req,
    input  logic [SRC_IDX_LEN-1:0] last_grant,
    output logic [SRC_IDX_LEN-1:0] idx,
    output logic                   any
);

    logic [SRC_IDX_LEN-1:0] w_cand [NUM_SRC];
    logic [NUM_SRC-1:0]     w_rot;

    // w_rot[k] is the request of the source k+1 places after last_grant
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_rot
            logic [SRC_IDX_LEN:0] w_sum;
            assign w_sum = {1'b0, last_grant} + (SRC_IDX_LEN+1)'(gi + 1);
            assign w_cand[gi] = (w_sum >= (SRC_IDX_LEN+1)'(NUM_SRC))
                              ? SRC_IDX_LEN'(w_sum - (SRC_IDX_LEN+1)'(NUM_SRC))
                              : w_sum[SRC_IDX_LEN-1:0];
            assign w_rot[gi] = req[w_cand[gi]];
        end
    endgenerate

    always_comb begin
        idx = last_grant;
        any = |req;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                idx = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin AXI-stream arbiter; grant held from first beat to last.
// Optional stall timeout with abort pulse when ARB_TIMEOUT_EN is defined.
module axis_pkt_arbiter
    import axis_arb_pkg::*;
#(
    parameter int DATAWIDTH      = 8,
    parameter int NUM_SRC        = DEF_NUM_SRC,
    parameter int SRC_IDX_LEN    = DEF_SRC_IDX_LEN,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SRC*DATAWIDTH-1:0]   s_axi_data,
    input  logic [NUM_SRC-1:0]             s_axi_valid,
    input  logic [NUM_SRC-1:0]             s_axi_last,
    output logic [NUM_SRC-1:0]             s_axi_rdy,
    output logic [DATAWIDTH-1:0]           m_axi_data,
    output logic                           m_axi_valid,
    output logic                           m_axi_last,
    input  logic                           m_axi_rdy,
    output logic [SRC_IDX_LEN-1:0]         grant_idx,
    output logic                           busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                           abort
`endif
);

    localparam logic [0:0] S_IDLE = ST_IDLE;
    localparam logic [0:0] S_PASS = ST_PASS;

    logic [0:0]             r_state;
    logic [SRC_IDX_LEN-1:0] r_grant;
    logic [SRC_IDX_LEN-1:0] r_last_grant;

    logic [SRC_IDX_LEN-1:0] w_pick_idx;
    logic                   w_pick_any;
    logic                   w_pass;
    logic                   w_g_valid;
    logic                   w_g_last;
    logic                   w_last_xfer;
    logic                   w_timeout;

    rr_pick #(
        .NUM_SRC     (NUM_SRC),
        .SRC_IDX_LEN (SRC_IDX_LEN)
    ) u_rr_pick (
        .req        (s_axi_valid),
        .last_grant (r_last_grant),
        .idx        (w_pick_idx),
        .any        (w_pick_any)
    );

    assign w_pass      = (r_state == S_PASS);
    assign w_g_valid   = s_axi_valid[r_grant];
    assign w_g_last    = s_axi_last[r_grant];
    assign w_last_xfer = m_axi_valid & m_axi_rdy & m_axi_last;

    assign m_axi_data  = s_axi_data[r_grant*DATAWIDTH +: DATAWIDTH];
    assign m_axi_valid = w_pass & w_g_valid;
    assign m_axi_last  = w_pass & w_g_last;
    assign grant_idx   = r_grant;
    assign busy        = w_pass;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_rdy
            assign s_axi_rdy[gi] = w_pass & (r_grant == SRC_IDX_LEN'(gi)) & m_axi_rdy;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_grant <= SRC_IDX_LEN'(NUM_SRC - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_any) begin
                        r_grant      <= w_pick_idx;
                        r_last_grant <= w_pick_idx;
                        r_state      <= S_PASS;
                    end
                end
                default: begin
                    // last_grant keeps the stalled source, pushing it to the back of the rotation
                    if (w_last_xfer || w_timeout) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_stall;
    logic             r_abort;

    assign w_timeout = w_pass & ~w_g_valid & (r_stall == CNT_W'(TIMEOUT_CYCLES - 1));
    assign abort     = r_abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
            r_abort <= 1'b0;
        end else begin
            r_abort <= w_timeout;
            if (!w_pass || w_g_valid || w_timeout) begin
                r_stall <= '0;
            end else begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Self-checking bench for axis_pkt_arbiter: cycle vector table plus scoreboarded packet sequences.
module tb_axis_pkt_arbiter;

    localparam int DW = 8;
    localparam int NS = 4;
    localparam int IW = 2;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS*DW-1:0]  s_data;
    logic [NS-1:0]     s_valid;
    logic [NS-1:0]     s_last;
    logic [NS-1:0]     s_rdy;
    logic [DW-1:0]     m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_rdy;
    logic [IW-1:0]     grant_idx;
    logic              busy;
    logic              abort;

    always #5 clk = ~clk;

    axis_pkt_arbiter #(
        .DATAWIDTH      (DW),
        .NUM_SRC        (NS),
        .SRC_IDX_LEN    (IW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_axi_data  (s_data),
        .s_axi_valid (s_valid),
        .s_axi_last  (s_last),
        .s_axi_rdy   (s_rdy),
        .m_axi_data  (m_data),
        .m_axi_valid (m_valid),
        .m_axi_last  (m_last),
        .m_axi_rdy   (m_rdy),
        .grant_idx   (grant_idx),
        .busy        (busy)
`ifdef ARB_TIMEOUT_EN
        ,
        .abort       (abort)
`endif
    );

`ifndef ARB_TIMEOUT_EN
    assign abort = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0] src;
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic [3:0] valid;
        logic [3:0] last;
        logic [7:0] d2;
        logic       mrdy;
        logic       e_mvalid;
        logic [7:0] e_mdata;
        logic       e_mlast;
        logic       e_busy;
        logic [1:0] e_grant;
        logic [3:0] e_srdy;
    } vec_t;

    beat_t       sb[$];
    logic [8:0]  src_q [NS][$];
    logic [NS-1:0] src_en;
    logic        prev_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_srcs();
        logic [8:0] h;
        for (int i = 0; i < NS; i++) begin
            if (src_q[i].size() > 0) begin
                h = src_q[i][0];
                s_data[i*DW +: DW] = h[7:0];
                s_last[i]          = h[8];
                s_valid[i]         = src_en[i];
            end else begin
                s_data[i*DW +: DW] = '0;
                s_last[i]          = 1'b0;
                s_valid[i]         = 1'b0;
            end
        end
        #1;
    endtask

    task automatic monitor();
        beat_t      e;
        logic [8:0] d;
        if (prev_last) begin
            chk("bubble_busy", 32'(busy), 0);
            chk("bubble_valid", 32'(m_valid), 0);
        end
        if (m_valid && m_rdy) begin
            $display("xfer src=%0d data=0x%02h last=%0b", grant_idx, m_data, m_last);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data 0x%02h from src %0d, expected no beat", m_data, grant_idx);
            end else begin
                e = sb.pop_front();
                chk("beat_src", 32'(grant_idx), 32'(e.src));
                chk("beat_data", 32'(m_data), 32'(e.data));
                chk("beat_last", 32'(m_last), 32'(e.last));
            end
        end
        prev_last = m_valid && m_rdy && m_last;
        for (int i = 0; i < NS; i++) begin
            if (s_valid[i] && s_rdy[i]) begin
                d = src_q[i].pop_front();
            end
        end
    endtask

    task automatic cycle();
        monitor();
        @(posedge clk);
        #1;
        drive_srcs();
    endtask

    task automatic run_until_empty(input int budget, output int n);
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d beats pending after %0d cycles", sb.size(), n);
        end
    endtask

    task automatic load_pkt(input int src, input logic [7:0] first, input int len, input bit expect_out);
        beat_t e;
        for (int b = 0; b < len; b++) begin
            e.src  = 2'(src);
            e.data = first + 8'(b);
            e.last = (b == len - 1);
            src_q[src].push_back({e.last, e.data});
            if (expect_out) sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_rdy = 1'b1;
        src_en = '1;
        prev_last = 1'b0;
        sb.delete();
        for (int i = 0; i < NS; i++) src_q[i].delete();
        s_valid = '1;
        s_last  = '1;
        s_data  = '1;
        @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_last", 32'(m_last), 0);
        chk("rst_s_rdy", 32'(s_rdy), 0);
        chk("rst_grant", 32'(grant_idx), 0);
        chk("rst_abort", 32'(abort), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_srcs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vec_t v;
        int   n;
        int   k;

        vecs[0] = '{valid:4'b0100, last:4'b0000, d2:8'hA1, mrdy:1'b1, e_mvalid:1'b0, e_mdata:8'h00, e_mlast:1'b0, e_busy:1'b0, e_grant:2'd0, e_srdy:4'b0000};
        vecs[1] = '{valid:4'b0100, last:4'b0000, d2:8'hA1, mrdy:1'b1, e_mvalid:1'b1, e_mdata:8'hA1, e_mlast:1'b0, e_busy:1'b1, e_grant:2'd2, e_srdy:4'b0100};
        vecs[2] = '{valid:4'b0100, last:4'b0000, d2:8'hA2, mrdy:1'b1, e_mvalid:1'b1, e_mdata:8'hA2, e_mlast:1'b0, e_busy:1'b1, e_grant:2'd2, e_srdy:4'b0100};
        vecs[3] = '{valid:4'b0100, last:4'b0100, d2:8'hA3, mrdy:1'b1, e_mvalid:1'b1, e_mdata:8'hA3, e_mlast:1'b1, e_busy:1'b1, e_grant:2'd2, e_srdy:4'b0100};
        vecs[4] = '{valid:4'b0000, last:4'b0000, d2:8'h00, mrdy:1'b1, e_mvalid:1'b0, e_mdata:8'h00, e_mlast:1'b0, e_busy:1'b0, e_grant:2'd2, e_srdy:4'b0000};

        // single 3-beat request from source 2, cycle by cycle
        do_reset();
        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            s_valid = v.valid;
            s_last  = v.last;
            s_data  = {8'h00, v.d2, 16'h0000};
            m_rdy   = v.mrdy;
            #1;
            $display("vec %0d valid=%b m_valid=%0b m_data=0x%02h busy=%0b grant=%0d", i, s_valid, m_valid, m_data, busy, grant_idx);
            chk("vec_m_valid", 32'(m_valid), 32'(v.e_mvalid));
            chk("vec_m_last", 32'(m_last), 32'(v.e_mlast));
            chk("vec_busy", 32'(busy), 32'(v.e_busy));
            chk("vec_grant", 32'(grant_idx), 32'(v.e_grant));
            chk("vec_s_rdy", 32'(s_rdy), 32'(v.e_srdy));
            if (v.e_mvalid) chk("vec_m_data", 32'(m_data), 32'(v.e_mdata));
            @(posedge clk);
            #1;
        end

        // all sources busy with 2-beat packets: order 0,1,2,3,0 with one bubble each
        do_reset();
        load_pkt(0, 8'h01, 2, 1);
        load_pkt(1, 8'h11, 2, 1);
        load_pkt(2, 8'h21, 2, 1);
        load_pkt(3, 8'h31, 2, 1);
        load_pkt(0, 8'h05, 2, 1);
        drive_srcs();
        run_until_empty(100, n);
        chk("rr_cycles", 32'(n), 15);

        // backpressure on source 1 with source 0 toggling valid meanwhile
        do_reset();
        load_pkt(1, 8'hB1, 4, 1);
        load_pkt(0, 8'hF1, 1, 1);
        src_en[0] = 1'b0;
        drive_srcs();
        cycle();
        cycle();
        m_rdy = 1'b0;
        src_en[0] = 1'b1;
        drive_srcs();
        for (int i = 0; i < 5; i++) begin
            chk("bp_s_rdy", 32'(s_rdy), 0);
            chk("bp_m_data", 32'(m_data), 32'h000000B2);
            chk("bp_grant", 32'(grant_idx), 1);
            chk("bp_m_valid", 32'(m_valid), 1);
            src_en[0] = ~src_en[0];
            cycle();
        end
        m_rdy = 1'b1;
        src_en[0] = 1'b1;
        drive_srcs();
        run_until_empty(50, n);

        // rotation after source 3, including one-beat packets
        do_reset();
        load_pkt(3, 8'h3A, 1, 1);
        drive_srcs();
        run_until_empty(20, n);
        chk("one_beat_cycles", 32'(n), 2);
        load_pkt(0, 8'h0B, 1, 1);
        load_pkt(3, 8'h3B, 1, 1);
        drive_srcs();
        run_until_empty(20, n);
        chk("rot_cycles", 32'(n), 4);

        // reset asserted at beat 2 of a 4-beat packet
        do_reset();
        load_pkt(1, 8'hC1, 4, 0);
        sb.push_back('{src:2'd1, data:8'hC1, last:1'b0});
        drive_srcs();
        cycle();
        cycle();
        chk("mid_m_data", 32'(m_data), 32'h000000C2);
        chk("mid_busy", 32'(busy), 1);
        chk("mid_grant", 32'(grant_idx), 1);
        rst = 1'b1;
        #1;
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_m_valid", 32'(m_valid), 0);
        chk("rstmid_grant", 32'(grant_idx), 0);
        @(posedge clk);
        #1;
        chk("rstmid_busy_next", 32'(busy), 0);
        chk("rstmid_s_rdy_next", 32'(s_rdy), 0);
        chk("rstmid_sb_drained", 32'(sb.size()), 0);

`ifdef ARB_TIMEOUT_EN
        // granted source stalls after beat 1; abort 9 cycles later, then source 1 granted
        do_reset();
        sb.push_back('{src:2'd0, data:8'hD1, last:1'b0});
        load_pkt(0, 8'hD1, 3, 0);
        load_pkt(1, 8'hE1, 1, 1);
        drive_srcs();
        cycle();
        src_en[0] = 1'b0;
        cycle();
        k = 1;
        while (abort !== 1'b1 && k < 40) begin
            cycle();
            k++;
        end
        $display("abort seen after %0d cycles", k);
        chk("to_abort_delay", 32'(k), 9);
        chk("to_abort_busy", 32'(busy), 0);
        chk("to_abort_m_valid", 32'(m_valid), 0);
        cycle();
        chk("to_abort_pulse", 32'(abort), 0);
        chk("to_next_grant", 32'(grant_idx), 1);
        chk("to_next_busy", 32'(busy), 1);
        run_until_empty(20, n);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
